// File: rtl/hz_pkg.sv
// Shared encodings, tracking-entry type and Tnew helper for the D-stage hazard scoreboard.
package hz_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [TNEW_W-1:0] tnew;
    } hz_entry_t;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hz_src_match.sv
// Resolves one D-stage source operand against the E/M/W entries: forward select and stall request.
module hz_src_match
    import hz_pkg::*;
(
    input  logic [REG_W-1:0]  a,
    input  logic [TNEW_W-1:0] tuse,
    input  hz_entry_t         e_ent,
    input  hz_entry_t         m_ent,
    input  hz_entry_t         w_ent,
    output logic [1:0]        fwd_sel,
    output logic              stall_req
);

    logic              hit;
    logic [TNEW_W-1:0] hit_tnew;
    logic [1:0]        hit_stage;

    always_comb begin
        fwd_sel   = FWD_RF;
        stall_req = 1'b0;
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_stage = FWD_RF;
        // a != 0 also guarantees $0 destinations can never match
        if (a != '0 && tuse != TUSE_NONE) begin
            if (e_ent.a3 == a) begin
                hit       = 1'b1;
                hit_tnew  = e_ent.tnew;
                hit_stage = FWD_E;
            end else if (m_ent.a3 == a) begin
                hit       = 1'b1;
                hit_tnew  = m_ent.tnew;
                hit_stage = FWD_M;
            end else if (w_ent.a3 == a) begin
                hit       = 1'b1;
                hit_tnew  = w_ent.tnew;
                hit_stage = FWD_W;
            end
            if (hit) begin
                if (hit_tnew == '0) begin
                    fwd_sel = hit_stage;
                end else if (hit_tnew > tuse) begin
                    stall_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/d_hazard_scoreboard.sv
// Tracks E/M/W destinations and Tnew; produces D-stage stall and per-operand forward selects.
module d_hazard_scoreboard
    import hz_pkg::*;
#(
    parameter int unsigned TNEW_MAX = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    input  logic [1:0]       D_Tuse1,
    input  logic [1:0]       D_Tuse2,
    input  logic [4:0]       D_A3,
    input  logic [1:0]       D_Tnew,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [4:0]       E_A3,
    output logic [4:0]       M_A3,
    output logic [4:0]       W_A3,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [TNEW_W-1:0] TNEW_CAP = (TNEW_MAX > 3) ? 2'd3 : TNEW_W'(TNEW_MAX);

    hz_entry_t        e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_req1, stall_req2;
    logic [1:0]       d_tnew_clamped;

    hz_src_match u_src1 (
        .a         (D_A1),
        .tuse      (D_Tuse1),
        .e_ent     (e_q),
        .m_ent     (m_q),
        .w_ent     (w_q),
        .fwd_sel   (fwd_sel1),
        .stall_req (stall_req1)
    );

    hz_src_match u_src2 (
        .a         (D_A2),
        .tuse      (D_Tuse2),
        .e_ent     (e_q),
        .m_ent     (m_q),
        .w_ent     (w_q),
        .fwd_sel   (fwd_sel2),
        .stall_req (stall_req2)
    );

    assign stall          = stall_req1 | stall_req2;
    assign d_tnew_clamped = (D_Tnew > TNEW_CAP) ? TNEW_CAP : D_Tnew;

    always_comb begin
        e_d   = stall ? '0 : hz_entry_t'{a3: D_A3, tnew: d_tnew_clamped};
        m_d   = hz_entry_t'{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
        w_d   = hz_entry_t'{a3: m_q.a3, tnew: sat_dec(m_q.tnew)};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, stall};
        // flush wins over the stall bubble but the stalled cycle is still counted
        if (flush) begin
            e_d = '0;
            m_d = '0;
            w_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign E_A3         = e_q.a3;
    assign M_A3         = m_q.a3;
    assign W_A3         = w_q.a3;
    assign stall_cycles = cnt_q;

endmodule

// File: doc/d_hazard_scoreboard.md
Name: d_hazard_scoreboard

Overview:
- Read-side counterpart of the E-stage destination-register selection.
- Tracks the destination register (A3) and remaining cycles-to-result (Tnew) of every in-flight instruction in E, M and W.
- Answers D-stage source reads (A1/A2) with a stall request and per-operand forward selects.
- Sits beside the D/E pipeline register and drives the D-stage stall and forward-mux controls for the 5-stage MIPS pipeline.

Parameters:
- TNEW_MAX, 2, largest legal Tnew at E entry (lw); larger inputs clamp to this value.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- D_A1  input  5  rs index of the instruction in D
- D_A2  input  5  rt index of the instruction in D
- D_Tuse1  input  2  cycles until A1 is consumed (0..2); 3 = operand unused
- D_Tuse2  input  2  same for A2
- D_A3  input  5  final destination of the instruction in D (0 = no write)
- D_Tnew  input  2  cycles after E entry until result is ready (0..2)
- flush  input  1  exception/eret flush; kills all in-flight non-committed entries
- stall  output  1  hold PC/F/D registers and insert a bubble into E
- fwd_sel1  output  2  A1 source: 0 regfile, 1 E, 2 M, 3 W
- fwd_sel2  output  2  A2 source, same encoding
- E_A3, M_A3, W_A3  output  5 each  tracked destinations, for debug and bench visibility
- stall_cycles  output  CNT_W  count of cycles with stall=1

Behaviour:
- State: three entries {A3[4:0], Tnew[1:0]} named E, M and W, plus stall_cycles.
- Reset (asynchronous): all entries 0, stall_cycles 0. Outputs then evaluate to stall=0 and fwd_sel1/2=0.
- Clock edge, no flush:
  - E <= stall ? {0,0} : {D_A3, min(D_Tnew, TNEW_MAX)}
  - M <= {E.A3, sat_dec(E.Tnew)}
  - W <= {M.A3, sat_dec(M.Tnew)}
  - sat_dec(0) = 0
- Clock edge with flush: E, M and W all load 0. Flush has priority over stall. stall_cycles still counts if stall=1 that cycle.
- stall_cycles increments by 1 on each edge where stall=1 and wraps modulo 2^CNT_W.
- Per source i (combinational, zero latency):
  - Inactive if A_i == 0 or Tuse_i == 3. Then fwd_sel_i = 0 and the source does not contribute to stall.
  - Otherwise find the youngest entry (priority E > M > W) whose A3 == A_i.
  - No match: fwd_sel_i = 0.
  - Match with Tnew == 0: fwd_sel_i = that stage (1/2/3).
  - Match with Tnew > 0: fwd_sel_i = 0. The source requests stall iff Tnew > Tuse_i. When Tnew <= Tuse_i the downstream stage forward resolves it and is out of scope here.
  - An older ready entry is never chosen over a younger matching one.
- stall = OR of both source stall requests.
- Stall holds D's inputs stable externally. The block re-evaluates each cycle and deasserts stall as soon as the blocking entry's Tnew decrements enough.
- A3 == 0 entries never match (register $0).
- A1 == A2 is legal: both operands are evaluated independently and yield identical results.

Decomposition:
- Shared package (hz_pkg):
  - FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3
  - TUSE_NONE=3
  - the entry struct/width constants
  - sat_dec function
- One natural sub-module: hz_src_match. Takes one {A, Tuse} against the three entries and returns {fwd_sel, stall_req}. It is instantiated twice, for A1 and A2.

Test Plan:
- Load-use: D_A3=8, D_Tnew=2, then next D_A1=8, Tuse1=0 -> stall=1 for 2 cycles. Then fwd_sel1=3 (W) and stall=0; stall_cycles=2.
- ALU chain: D_A3=9, Tnew=1, then A2=9, Tuse2=1 -> stall=0, fwd_sel2=0. One cycle later (entry in M, Tnew 0) the same A2 gives fwd_sel2=2.
- Youngest-wins: E.A3=5 with Tnew=1 and M.A3=5 with Tnew=0; D_A1=5, Tuse1=0 -> stall=1, fwd_sel1=0 (M not selected).
- $0 and unused operands: D_A1=0 with E.A3=0, plus D_A2=7 with Tuse2=3 while E.A3=7 has Tnew=2 -> stall=0, fwd_sel1=fwd_sel2=0.
- Flush while stalled: load in E (Tnew=2) stalling D; assert flush -> next cycle E/M/W A3=0, stall=0. Flush overrides the stall bubble.
- Async reset mid-stall: assert reset between edges -> E_A3/M_A3/W_A3=0 and stall=0 immediately, with stall_cycles=0.
